// File: rtl/multiplier_pkg.sv
// Shared width and FSM encoding for the shift-add reduction blocks.
package multiplier_pkg;

  localparam int DATA_LENGTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FINAL = 2'd2,
    OUT   = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: one-hot grant to the first request after the pointer.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);

  logic          w_found;
  logic [IW-1:0] w_idx;

  always_comb begin
    grant_o = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 1; i <= N; i++) begin
      w_idx = IW'((int'(ptr_i) + i) % N);
      if (!w_found && req_i[w_idx]) begin
        grant_o[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shiftadd_parallel.sv
// One combinational reduction pass: a restoring chain that subtracts m<<s,
// from the highest legal shift down to 0, wherever the partial value allows it.
module shiftadd_parallel
  import multiplier_pkg::*;
(
  input  logic [DATA_LENGTH-1:0] acc_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  input  logic [DATA_LENGTH-1:0] m_bl_i,
  output logic [DATA_LENGTH-1:0] acc_o
);

  localparam int WW = 2 * DATA_LENGTH;

  logic [DATA_LENGTH:0][DATA_LENGTH-1:0] w_stage;

  assign w_stage[0] = acc_i;

  // Shifts above DATA_LENGTH - m_bl would push m past the datapath width.
  for (genvar gi = 0; gi < DATA_LENGTH; gi++) begin : g_step
    localparam int SH = DATA_LENGTH - 1 - gi;
    logic [WW-1:0] w_sub;
    logic          w_en;
    assign w_sub = {{DATA_LENGTH{1'b0}}, m_i} << SH;
    assign w_en  = ((32'(SH) + 32'(m_bl_i)) <= 32'(DATA_LENGTH)) &&
                   ({{DATA_LENGTH{1'b0}}, w_stage[gi]} >= w_sub);
    assign w_stage[gi+1] = w_en ? (w_stage[gi] - w_sub[DATA_LENGTH-1:0]) : w_stage[gi];
  end

  assign acc_o = w_stage[DATA_LENGTH];

endmodule

// File: rtl/shiftadd_red_sched.sv
// Arbitrated modular reducer: grants one requester, runs NUM_RED shift-add
// passes on a shared stage, finishes with a conditional subtract and holds the result.
module shiftadd_red_sched
  import multiplier_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int NUM_RED = 3,
  localparam int IDW = $clog2(NUM_REQ),
  localparam int CW  = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NUM_REQ-1:0]                     req_valid_i,
  output logic [NUM_REQ-1:0]                     req_ready_o,
  input  logic [NUM_REQ-1:0][DATA_LENGTH-1:0]    x_i,
  input  logic [NUM_REQ-1:0][DATA_LENGTH-1:0]    m_i,
  input  logic [NUM_REQ-1:0][DATA_LENGTH-1:0]    m_bl_i,
  output logic [DATA_LENGTH-1:0]                 result_o,
  output logic [IDW-1:0]                         result_id_o,
  output logic                                   err_o,
  output logic                                   valid_o,
  input  logic                                   ready_i,
  output logic                                   busy_o
);

  state_e                 r_state;
  logic [DATA_LENGTH-1:0] r_acc;
  logic [DATA_LENGTH-1:0] r_m;
  logic [DATA_LENGTH-1:0] r_m_bl;
  logic [IDW-1:0]         r_id;
  logic [IDW-1:0]         r_last;
  logic [CW-1:0]          r_cnt;
  logic [DATA_LENGTH-1:0] r_result;
  logic [IDW-1:0]         r_result_id;
  logic                   r_err;
  logic                   r_valid;

  logic [NUM_REQ-1:0]     w_grant;
  logic [IDW-1:0]         w_grant_idx;
  logic                   w_xfer;
  logic [DATA_LENGTH-1:0] w_red;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i   (req_valid_i),
    .ptr_i   (r_last),
    .grant_o (w_grant)
  );

  shiftadd_parallel u_red (
    .acc_i  (r_acc),
    .m_i    (r_m),
    .m_bl_i (r_m_bl),
    .acc_o  (w_red)
  );

  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_grant_idx = IDW'(i);
    end
  end

  // Gated by rst_ni so no grant is visible while reset is held.
  assign req_ready_o = (r_state == IDLE && rst_ni) ? w_grant : '0;
  assign w_xfer      = |(req_valid_i & req_ready_o);
  assign busy_o      = (r_state != IDLE);
  assign result_o    = r_result;
  assign result_id_o = r_result_id;
  assign err_o       = r_err;
  assign valid_o     = r_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_m         <= '0;
      r_m_bl      <= '0;
      r_id        <= '0;
      r_last      <= IDW'(NUM_REQ - 1);
      r_cnt       <= '0;
      r_result    <= '0;
      r_result_id <= '0;
      r_err       <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_acc   <= x_i[w_grant_idx];
            r_m     <= m_i[w_grant_idx];
            r_m_bl  <= m_bl_i[w_grant_idx];
            r_id    <= w_grant_idx;
            r_last  <= w_grant_idx;
            r_cnt   <= '0;
            // A zero modulus has nothing to reduce; go straight to the error result.
            r_state <= (m_i[w_grant_idx] == '0) ? FINAL : ITER;
          end
        end
        ITER: begin
          r_acc <= w_red;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(NUM_RED - 1)) r_state <= FINAL;
        end
        FINAL: begin
          if (r_m == '0) begin
            r_result <= '0;
            r_err    <= 1'b1;
          end else begin
            r_result <= (r_acc >= r_m) ? (r_acc - r_m) : r_acc;
            r_err    <= 1'b0;
          end
          r_result_id <= r_id;
          r_valid     <= 1'b1;
          r_state     <= OUT;
        end
        OUT: begin
          if (ready_i) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
